// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline.
// Define PIPE_STALL_CNT_EN to build the saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int unsigned MD_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        ex_branch_taken,
   input  logic        id_md_start,
   input  logic        id_reads_hilo,
   input  logic        ext_hold,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_WAIT = 1'b1;
   localparam logic [7:0] LAT8    = 8'(MD_LAT);

   logic [0:0] state;
   logic [0:0] state_nxt;
   logic [7:0] md_cnt;
   logic [7:0] md_cnt_nxt;

   logic load_use;
   logic md_lock;
   logic go;
   logic accept;

   assign md_busy = (state == MD_WAIT);
   assign md_done = md_busy && (md_cnt == 8'd1);

   assign load_use = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) ||
                      (id_uses_rt && (ex_rt == id_rt)));

   assign md_lock = md_busy && (id_md_start || id_reads_hilo);

   // go: the "no hazard, everything advances" case
   assign go = rst && !ext_hold && !ex_branch_taken &&
               !load_use && !md_lock;

   assign accept = go && id_md_start;

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      priority case (1'b1)
         !rst: begin
         end
         ext_hold: begin
         end
         ex_branch_taken: begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         (load_use || md_lock): begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end
         default: begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      endcase
   end

   // md_cnt keeps running under ext_hold; the unit is not stalled by memory
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      unique case (state)
         RUN: begin
            if (accept) begin
               state_nxt  = MD_WAIT;
               md_cnt_nxt = LAT8;
            end
         end
         MD_WAIT: begin
            md_cnt_nxt = (md_cnt == 8'd0) ? 8'd0 : md_cnt - 8'd1;
            if (md_cnt <= 8'd1) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt  = RUN;
            md_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 32'd0;
      end else if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Instance a uses MD_LAT=4, instance b MD_LAT=32; inputs are shared.
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] EN_RUN   = 7'b1111100;
   localparam logic [6:0] EN_STALL = 7'b0011101;
   localparam logic [6:0] EN_BR    = 7'b1111111;
   localparam logic [6:0] EN_OFF   = 7'b0000000;

   logic clk;
   logic rst;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic id_uses_rt;
   logic ex_memread;
   logic [4:0] ex_rt;
   logic ex_branch_taken;
   logic id_md_start;
   logic id_reads_hilo;
   logic ext_hold;

   logic pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
   logic ifid_flush_a, idex_flush_a, md_busy_a, md_done_a;
   logic [31:0] stall_cnt_a;
   logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
   logic ifid_flush_b, idex_flush_b, md_busy_b, md_done_b;
   logic [31:0] stall_cnt_b;

   logic [6:0] en_a;
   logic [6:0] en_b;

   int checks = 0;
   int errors = 0;

   assign en_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a,
                  memwb_en_a, ifid_flush_a, idex_flush_a};
   assign en_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b,
                  memwb_en_b, ifid_flush_b, idex_flush_b};

   pipe_hazard_ctrl #(.MD_LAT(4)) dut_a (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken),
      .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
      .ext_hold(ext_hold),
      .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a),
      .exmem_en(exmem_en_a), .memwb_en(memwb_en_a),
      .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
      .md_busy(md_busy_a), .md_done(md_done_a),
      .stall_cnt(stall_cnt_a)
   );

   pipe_hazard_ctrl #(.MD_LAT(32)) dut_b (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken),
      .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
      .ext_hold(ext_hold),
      .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b),
      .exmem_en(exmem_en_b), .memwb_en(memwb_en_b),
      .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
      .md_busy(md_busy_b), .md_done(md_done_b),
      .stall_cnt(stall_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      id_rs = 5'd0;
      id_rt = 5'd0;
      id_uses_rt = 1'b0;
      ex_memread = 1'b0;
      ex_rt = 5'd0;
      ex_branch_taken = 1'b0;
      id_md_start = 1'b0;
      id_reads_hilo = 1'b0;
      ext_hold = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clear_in();
      #2;
      chk("rst_en", 32'(en_a), 32'(EN_OFF));
      chk("rst_busy", 32'(md_busy_a), 32'd0);
      chk("rst_done", 32'(md_done_a), 32'd0);
      chk("rst_stall", stall_cnt_a, 32'd0);

      @(negedge clk); rst = 1'b1; #1;
      chk("run_after_rst", 32'(en_a), 32'(EN_RUN));

      @(negedge clk);
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
      chk("lu_rs", 32'(en_a), 32'(EN_STALL));

      @(negedge clk);
      ex_rt = 5'd0; id_rs = 5'd0; #1;
      chk("lu_r0", 32'(en_a), 32'(EN_RUN));

      @(negedge clk);
      ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1; #1;
      chk("lu_rt", 32'(en_a), 32'(EN_STALL));

      @(negedge clk);
      id_uses_rt = 1'b0; #1;
      chk("lu_rt_unused", 32'(en_a), 32'(EN_RUN));

      @(negedge clk);
      id_uses_rt = 1'b1; ex_memread = 1'b0; #1;
      chk("no_load", 32'(en_a), 32'(EN_RUN));

      @(negedge clk);
      ex_memread = 1'b1; ex_branch_taken = 1'b1; #1;
      chk("br_lu", 32'(en_a), 32'(EN_BR));

      @(negedge clk);
      ext_hold = 1'b1; #1;
      chk("hold_br", 32'(en_a), 32'(EN_OFF));

      @(negedge clk);
      ext_hold = 1'b0; #1;
      chk("br_again", 32'(en_a), 32'(EN_BR));

      @(negedge clk);
      ex_branch_taken = 1'b0; #1;
      chk("lu_again", 32'(en_a), 32'(EN_STALL));

      @(negedge clk);
      clear_in(); #1;
      chk("clear_run", 32'(en_a), 32'(EN_RUN));

`ifdef PIPE_STALL_CNT_EN
      force dut_a.stall_q = 32'hFFFF_FFFE;
      #1 release dut_a.stall_q;
      ext_hold = 1'b1;
      for (int k = 0; k < 3; k++) @(negedge clk);
      #1;
      chk("stall_sat", stall_cnt_a, 32'hFFFF_FFFF);
`else
      ext_hold = 1'b1;
      for (int k = 0; k < 3; k++) @(negedge clk);
      #1;
      chk("stall_off", stall_cnt_a, 32'd0);
`endif
      ext_hold = 1'b0;

      @(negedge clk); rst = 1'b0; #1;
      chk("rst2_stall", stall_cnt_a, 32'd0);
      @(negedge clk); rst = 1'b1;

      // accept a div, then hold mfhi behind it
      @(negedge clk);
      id_md_start = 1'b1; #1;
      chk("acc_en", 32'(en_a), 32'(EN_RUN));
      chk("acc_busy", 32'(md_busy_a), 32'd0);

      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         id_md_start = 1'b0; id_reads_hilo = 1'b1; #1;
         chk("md_en", 32'(en_a), 32'(EN_STALL));
         chk("md_busy", 32'(md_busy_a), 32'd1);
         chk("md_done", 32'(md_done_a), 32'(k == 4));
      end

      @(negedge clk); #1;
      chk("mfhi_issue", 32'(en_a), 32'(EN_RUN));
      chk("md_idle", 32'(md_busy_a), 32'd0);
      chk("md_done_end", 32'(md_done_a), 32'd0);
`ifdef PIPE_STALL_CNT_EN
      chk("md_stall_cnt", stall_cnt_a, 32'd4);
`else
      chk("md_stall_cnt", stall_cnt_a, 32'd0);
`endif
      chk("b_busy5", 32'(md_busy_b), 32'd1);

      for (int k = 6; k <= 8; k++) begin
         @(negedge clk);
         id_reads_hilo = 1'b0; ext_hold = 1'b1; #1;
         chk("hold_md_en", 32'(en_b), 32'(EN_OFF));
         chk("hold_md_busy", 32'(md_busy_b), 32'd1);
      end

      for (int k = 9; k <= 33; k++) begin
         @(negedge clk);
         ext_hold = 1'b0; #1;
         chk("b_busy", 32'(md_busy_b), 32'(k <= 32));
         chk("b_done", 32'(md_done_b), 32'(k == 32));
         chk("b_en", 32'(en_b), 32'(EN_RUN));
      end

      // second div on b, async reset when md_cnt is 10
      @(negedge clk);
      id_md_start = 1'b1; #1;
      chk("acc2_busy", 32'(md_busy_b), 32'd0);
      chk("acc2_en", 32'(en_b), 32'(EN_RUN));

      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         id_md_start = (k == 2); #1;
         if (k == 2) chk("md_start_busy", 32'(en_b), 32'(EN_STALL));
         if (k == 23) begin
            chk("pre_rst_busy", 32'(md_busy_b), 32'd1);
            #1 rst = 1'b0; #1;
            chk("async_busy", 32'(md_busy_b), 32'd0);
            chk("async_done", 32'(md_done_b), 32'd0);
            chk("async_en", 32'(en_b), 32'(EN_OFF));
            chk("async_stall", stall_cnt_b, 32'd0);
         end
      end

      @(negedge clk);
      rst = 1'b1; #1;
      chk("rel_en", 32'(en_b), 32'(EN_RUN));
      chk("rel_busy", 32'(md_busy_b), 32'd0);
      @(negedge clk); #1;
      chk("rel_busy2", 32'(md_busy_b), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
